// File: rtl/chu_led_sequencer_if.sv
// FPro-style MMIO slot bus used by the LED sequencer core.
// The processor side drives the strobes; the core returns combinational read data.
interface chu_led_sequencer_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (output cs, read, write, addr, wr_data, input rd_data);
    modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/chu_led_sequencer.sv
// MMIO slot core that steps a W-bit output through a programmable table of
// (pattern, dwell) entries, one-shot or looping, paced by a tick prescaler.
module chu_led_sequencer #(
    parameter int W            = 4,
    parameter int DEPTH        = 8,
    parameter int PRESCALE_DEF = 100_000
) (
    input  logic                      clk,
    input  logic                      reset,
    chu_led_sequencer_if.slave        bus,
    output logic [W-1:0]              dout
);
    localparam int         IDX_W   = $clog2(DEPTH);
    localparam logic [4:0] LEN_MAX = 5'(DEPTH);
    localparam logic [5:0] TBL_END = 6'(8 + DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, DWELL, DONE} state_t;

    state_t            state, state_next;
    logic [4:0]        idx, idx_next;
    logic              loop_reg;
    logic [23:0]       presc_reg;
    logic [4:0]        len_reg;
    logic [W-1:0]      tbl_pat   [DEPTH];
    logic [15:0]       tbl_dwell [DEPTH];
    logic [15:0]       dwell_cnt;
    logic [23:0]       pre_cnt;

    logic              wr_en, ctrl_wr, start_cmd, stop_cmd;
    logic              tbl_hit;
    logic [IDX_W-1:0]  tbl_sel;
    logic [23:0]       presc_eff;
    logic [15:0]       cur_dwell;
    logic              tick, last_tick, at_end;
    logic              busy, done;
    logic              unused_read;

    assign wr_en     = bus.cs && bus.write;
    assign ctrl_wr   = wr_en && (bus.addr == 5'd0);
    assign stop_cmd  = ctrl_wr && bus.wr_data[2];
    assign start_cmd = ctrl_wr && bus.wr_data[0] && !bus.wr_data[2];

    // Reads have no side effects, so the read strobe itself is never needed.
    assign unused_read = bus.read;

    assign tbl_hit   = ({1'b0, bus.addr} >= 6'd8) && ({1'b0, bus.addr} < TBL_END);
    assign tbl_sel   = IDX_W'(bus.addr - 5'd8);

    assign presc_eff = (presc_reg == 24'd0) ? 24'd1 : presc_reg;
    assign cur_dwell = tbl_dwell[idx[IDX_W-1:0]];
    // >= keeps the prescaler from running to wrap if PRESC shrinks mid-count.
    assign tick      = (state == DWELL) && (pre_cnt >= presc_eff - 24'd1);
    assign last_tick = tick && (dwell_cnt == 16'd1);
    // Covers LEN being reduced below the running index.
    assign at_end    = (idx + 5'd1) >= len_reg;

    assign busy = (state == LOAD) || (state == DWELL);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every register
            // samples pre-edge values; blocking here would create ordering races.
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output; a missing
        // branch would otherwise infer a latch.
        state_next = state;
        idx_next   = idx;
        if (stop_cmd) begin
            state_next = IDLE;
            idx_next   = '0;
        end else if (start_cmd) begin
            state_next = LOAD;
            idx_next   = '0;
        end else begin
            case (state)
                LOAD: state_next = DWELL;
                DWELL: begin
                    if (last_tick) begin
                        if (!at_end) begin
                            idx_next   = idx + 5'd1;
                            state_next = LOAD;
                        end else if (loop_reg) begin
                            idx_next   = '0;
                            state_next = LOAD;
                        end else begin
                            state_next = DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout      <= '0;
            dwell_cnt <= '0;
            pre_cnt   <= '0;
        end else begin
            if (stop_cmd)
                dout <= '0;
            else if (state == LOAD)
                dout <= tbl_pat[idx[IDX_W-1:0]];

            if (state == LOAD) begin
                dwell_cnt <= (cur_dwell == 16'd0) ? 16'd1 : cur_dwell;
                pre_cnt   <= '0;
            end else if (state == DWELL) begin
                if (tick) begin
                    pre_cnt <= '0;
                    if (dwell_cnt != 16'd1)
                        dwell_cnt <= dwell_cnt - 16'd1;
                end else begin
                    pre_cnt <= pre_cnt + 24'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loop_reg  <= 1'b0;
            presc_reg <= 24'(PRESCALE_DEF);
            len_reg   <= LEN_MAX;
            // NOTE: the table is small enough to live in flops, so it is reset
            // to a known state; a larger RAM-backed table would not be.
            for (int i = 0; i < DEPTH; i++) begin
                tbl_pat[i]   <= '0;
                tbl_dwell[i] <= '0;
            end
        end else if (wr_en) begin
            if (tbl_hit) begin
                tbl_pat[tbl_sel]   <= bus.wr_data[W-1:0];
                tbl_dwell[tbl_sel] <= bus.wr_data[31:16];
            end else begin
                case (bus.addr)
                    5'd0: loop_reg  <= bus.wr_data[1];
                    5'd2: presc_reg <= bus.wr_data[23:0];
                    5'd3: begin
                        if (bus.wr_data[4:0] == 5'd0)
                            len_reg <= 5'd1;
                        else if (bus.wr_data[4:0] > LEN_MAX)
                            len_reg <= LEN_MAX;
                        else
                            len_reg <= bus.wr_data[4:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus.rd_data = '0;
        if (tbl_hit) begin
            bus.rd_data = {tbl_dwell[tbl_sel], {(16 - W){1'b0}}, tbl_pat[tbl_sel]};
        end else begin
            case (bus.addr)
                5'd0: bus.rd_data = {30'd0, loop_reg, 1'b0};
                5'd1: bus.rd_data = {24'd0, idx[3:0], 2'b00, done, busy};
                5'd2: bus.rd_data = {8'd0, presc_reg};
                5'd3: bus.rd_data = {27'd0, len_reg};
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_chu_led_sequencer.sv
// Scoreboard bench for chu_led_sequencer: drivers queue expected reads, dout
// probes and dout segments (pattern, cycle count); a negedge monitor pops and compares.
module tb_chu_led_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] dout;
    logic       probe = 1'b0;
    logic       seg_en = 1'b0;

    chu_led_sequencer_if bus ();

    chu_led_sequencer #(.W(4), .DEPTH(8), .PRESCALE_DEF(100_000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t rd_q[$];
    exp_t dout_q[$];
    exp_t seg_q[$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] seg_word(input logic [3:0] pat, input int len);
        return {16'(len), 12'd0, pat};
    endfunction

    // Monitor: compares every presented read, every dout probe, and every
    // completed run of a non-zero dout value against the queued expectations.
    logic [3:0] seg_val = '0;
    int         seg_len = 0;

    always @(negedge clk) begin
        exp_t e;
        if (bus.cs && bus.read) begin
            if (rd_q.size() == 0) check("read underflow", 32'd1, 32'd0);
            else begin
                e = rd_q.pop_front();
                check(e.name, bus.rd_data, e.exp);
            end
        end
        if (probe) begin
            if (dout_q.size() == 0) check("probe underflow", 32'd1, 32'd0);
            else begin
                e = dout_q.pop_front();
                check(e.name, {28'd0, dout}, e.exp);
            end
        end
        if (dout !== seg_val) begin
            if (seg_en && seg_val != 4'd0) begin
                if (seg_q.size() == 0) check("unexpected segment", seg_word(seg_val, seg_len), 32'd0);
                else begin
                    e = seg_q.pop_front();
                    check(e.name, seg_word(seg_val, seg_len), e.exp);
                end
            end
            seg_val = dout;
            seg_len = 1;
        end else begin
            seg_len++;
        end
    end

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        bus.cs = 1'b1; bus.write = 1'b1; bus.addr = a; bus.wr_data = d;
        @(posedge clk); #1;
        bus.cs = 1'b0; bus.write = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, input logic [31:0] e, input string nm);
        bus.cs = 1'b1; bus.read = 1'b1; bus.addr = a;
        rd_q.push_back('{e, nm});
        @(posedge clk); #1;
        bus.cs = 1'b0; bus.read = 1'b0;
    endtask

    task automatic probe_dout(input logic [3:0] e, input string nm);
        probe = 1'b1;
        dout_q.push_back('{{28'd0, e}, nm});
        @(posedge clk); #1;
        probe = 1'b0;
    endtask

    task automatic expect_seg(input logic [3:0] pat, input int len, input string nm);
        seg_q.push_back('{seg_word(pat, len), nm});
    endtask

    task automatic seg_drained(input string nm);
        check(nm, 32'(seg_q.size()), 32'd0);
    endtask

    // Stop and let the monitor see dout fall to 0 before segments are re-armed.
    task automatic stop_and_rearm();
        seg_en = 1'b0;
        bus_write(5'd0, 32'h4);
        @(posedge clk); #1;
        seg_en = 1'b1;
    endtask

    task automatic load_std_table();
        bus_write(5'd2, 32'd4);
        bus_write(5'd3, 32'd3);
        bus_write(5'd8,  32'h0002_0001);
        bus_write(5'd9,  32'h0001_0002);
        bus_write(5'd10, 32'h0003_0004);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        bus.addr = '0; bus.wr_data = '0;
        repeat (2) @(posedge clk); #1;
        reset = 1'b0;

        // Reset values
        bus_read(5'd0, 32'h0, "reset CTRL");
        bus_read(5'd1, 32'h0, "reset STATUS");
        bus_read(5'd2, 32'd100_000, "reset PRESC");
        bus_read(5'd3, 32'd8, "reset LEN");
        bus_read(5'd8, 32'h0, "reset TABLE0");
        probe_dout(4'd0, "reset dout");

        // One-shot: 1 for 9, 2 for 5, 4 for 13, then DONE holding 4
        load_std_table();
        seg_en = 1'b1;
        expect_seg(4'd1, 9, "oneshot seg pat1");
        expect_seg(4'd2, 5, "oneshot seg pat2");
        bus_write(5'd0, 32'h1);
        bus_read(5'd1, 32'h01, "oneshot busy after start");
        repeat (25) @(posedge clk); #1;
        bus_read(5'd1, 32'h21, "oneshot busy last cycle");
        bus_read(5'd1, 32'h22, "oneshot done");
        probe_dout(4'd4, "oneshot dout holds");
        seg_drained("oneshot segments drained");
        stop_and_rearm();

        // Loop, then clear loop mid-T1 of the second pass
        expect_seg(4'd1, 9,  "loop seg pat1 a");
        expect_seg(4'd2, 5,  "loop seg pat2 a");
        expect_seg(4'd4, 13, "loop seg pat4 a");
        expect_seg(4'd1, 9,  "loop seg pat1 b");
        expect_seg(4'd2, 5,  "loop seg pat2 b");
        bus_write(5'd0, 32'h3);
        bus_read(5'd0, 32'h2, "loop CTRL readback");
        repeat (37) @(posedge clk); #1;
        bus_write(5'd0, 32'h0);
        repeat (14) @(posedge clk); #1;
        bus_read(5'd1, 32'h21, "loop busy last cycle");
        bus_read(5'd1, 32'h22, "loop ends done");
        bus_read(5'd0, 32'h0, "loop cleared CTRL");
        probe_dout(4'd4, "loop dout holds");
        seg_drained("loop segments drained");
        stop_and_rearm();

        // Boundaries
        bus_write(5'd3, 32'd0);
        bus_read(5'd3, 32'd1, "LEN 0 reads 1");
        bus_write(5'd3, 32'd20);
        bus_read(5'd3, 32'd8, "LEN 20 clipped");
        bus_write(5'd3, 32'd2);
        bus_write(5'd2, 32'd0);
        bus_read(5'd2, 32'd0, "PRESC 0 raw");
        bus_write(5'd8, 32'h0000_0003);
        bus_write(5'd9, 32'h0000_0005);
        bus_write(5'd15, 32'h1234_000A);
        bus_read(5'd15, 32'h1234_000A, "TABLE7 readback");
        bus_read(5'd16, 32'h0, "addr 16 reads 0");
        bus_read(5'd5, 32'h0, "addr 5 reads 0");
        expect_seg(4'd3, 2, "min entry 2 cycles");
        bus_write(5'd0, 32'h1);
        repeat (3) @(posedge clk); #1;
        bus_read(5'd1, 32'h11, "min entry busy idx1");
        bus_read(5'd1, 32'h12, "min entry done idx1");
        seg_drained("min segments drained");
        stop_and_rearm();

        // Live edit of T1 while T0 is dwelling
        load_std_table();
        expect_seg(4'd1, 9, "live seg pat1");
        expect_seg(4'd9, 5, "live seg pat9");
        bus_write(5'd0, 32'h1);
        bus_write(5'd9, 32'h0001_0009);
        repeat (30) @(posedge clk); #1;
        bus_read(5'd1, 32'h22, "live done");
        probe_dout(4'd4, "live dout holds");
        seg_drained("live segments drained");
        stop_and_rearm();
        seg_en = 1'b0;

        // Start and stop in one write: stop wins
        bus_write(5'd9, 32'h0001_0002);
        bus_write(5'd0, 32'h1);
        repeat (4) @(posedge clk); #1;
        bus_write(5'd0, 32'h5);
        bus_read(5'd1, 32'h0, "collision STATUS idle");
        bus_read(5'd0, 32'h0, "collision CTRL");
        probe_dout(4'd0, "collision dout 0");

        // Async reset mid-DWELL
        bus_write(5'd0, 32'h3);
        repeat (5) @(posedge clk); #1;
        reset = 1'b1;
        #1;
        bus_read(5'd1, 32'h0, "midrun reset STATUS");
        bus_read(5'd2, 32'd100_000, "midrun reset PRESC");
        bus_read(5'd3, 32'd8, "midrun reset LEN");
        bus_read(5'd8, 32'h0, "midrun reset TABLE0");
        bus_read(5'd0, 32'h0, "midrun reset CTRL");
        probe_dout(4'd0, "midrun reset dout");
        reset = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("read queue drained", 32'(rd_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
